ar_channel_router: RTL and testbench
====================================

# ar_channel_router

Read-address (AR) channel router that sits directly downstream of the 2-master arbiter in the AXI interconnect. It takes the arbiter's one-hot grant, accepts the granted master's AR request into a single-entry holding register, decodes the address to a target slave, and drives that slave until it accepts. When the slave accepts, the router returns `HandShake` to the arbiter so the arbiter can release the grant. It also caps the number of outstanding read bursts.

## Interface
- `MAX_OUTSTANDING`, 4: maximum issued-but-uncompleted read bursts, range 1..7.
- `S0_PAGE`, 16'h0000: ARADDR[31:16] value that selects slave 0 (IM).
- `S1_PAGE`, 16'h0001: ARADDR[31:16] value that selects slave 1 (DM).
- `ACLK` in 1: single clock; all logic is on the rising edge.
- `ARESET` in 1: synchronous, active-high reset.
- `grant_2M` in 2: one-hot grant from the arbiter; bit0 = M0, bit1 = M1.
- `HandShake` out 1: one-cycle pulse to the arbiter when the slave accepts an address.
- `ARID_M0`, `ARID_M1` in 4: master transaction IDs.
- `ARADDR_M0`, `ARADDR_M1` in 32: master read addresses.
- `ARLEN_M0`, `ARLEN_M1` in 4: master burst lengths.
- `ARSIZE_M0`, `ARSIZE_M1` in 3: master transfer sizes.
- `ARBURST_M0`, `ARBURST_M1` in 2: master burst types.
- `ARVALID_M0`, `ARVALID_M1` in 1: master address-valid.
- `ARREADY_M0`, `ARREADY_M1` out 1: router accepts the master's request.
- `ARID_S` out 8: shared to all slaves; {4'b0001, ID} for M0, {4'b0010, ID} for M1.
- `ARADDR_S` out 32, `ARLEN_S` out 4, `ARSIZE_S` out 3, `ARBURST_S` out 2: shared AR payload to all slaves.
- `ARVALID_S` out 3: one-hot per slave; [0] = S0, [1] = S1, [2] = default slave.
- `ARREADY_S` in 3: per-slave ready.
- `RDONE` in 1: one-cycle pulse when any read burst completes (RLAST handshake).
- `outstanding` out 3: current count of outstanding read bursts.

## Operation
- FSM has two states.
  - IDLE: no request is held.
  - SEND: a request is held and `ARVALID_S` is being driven.
- Capture in IDLE:
  - Condition: `grant_2M` is 2'b01 or 2'b10, the granted master's ARVALID = 1, and `outstanding` < MAX_OUTSTANDING.
  - Action: the granted master's ARREADY = 1 combinationally that cycle. Payload, master index and decoded slave are registered. Next state is SEND.
- No capture in IDLE when `grant_2M` is 2'b00 or 2'b11, the granted master's ARVALID = 0, or the outstanding limit is reached. Both ARREADY outputs stay 0.
- Address decode uses the captured ARADDR[31:16]:
  - equal to S0_PAGE → S0.
  - equal to S1_PAGE → S1.
  - anything else → default slave (bit 2).
- SEND:
  - ARVALID_S[target] = 1; all payload outputs are held stable.
  - On ARREADY_S[target] = 1: `HandShake` = 1 combinationally that cycle, `outstanding` increments, next state is IDLE.
  - ARREADY_S on non-target bits is ignored.
- `ARREADY_M*` is always 0 in SEND. The holding register is a single entry with no bypass.
- `outstanding` counter:
  - +1 on slave accept, −1 on RDONE.
  - Both in the same cycle → unchanged.
  - RDONE when the count is 0 → ignored; the counter saturates at 0 and never wraps.
  - The count can never exceed MAX_OUTSTANDING because capture is blocked at the limit.

## Timing
- Reset values, applied on the first edge with ARESET = 1:
  - state = IDLE.
  - `ARVALID_S` = 3'b000; `ARREADY_M0` = `ARREADY_M1` = 0; `HandShake` = 0.
  - `outstanding` = 0.
  - `ARID_S`, `ARADDR_S`, `ARLEN_S`, `ARSIZE_S`, `ARBURST_S` = 0.
- Latency:
  - Master handshake in cycle N → `ARVALID_S` high in cycle N+1.
  - Earliest slave accept is N+1, with `HandShake` in N+1.
  - Earliest next capture is N+2.
- Stalls: the slave may hold ARREADY low indefinitely. `ARVALID_S` and the payload must not change until it accepts.
- Grant changes while in SEND are ignored; the held request completes first.
- Reset in the middle of SEND drops the held request. `ARVALID_S` is 0 on the cycle after the reset edge and `outstanding` clears to 0.
- ARREADY_M* and `HandShake` are combinational from registered state and the inputs. All other outputs are registered.

## Test plan
- Basic M0 path: reset; `grant_2M` = 01, ARVALID_M0 = 1, ARADDR_M0 = 0x0001_0040, ARID_M0 = 3, with ARREADY_S = 111 held constantly.
  - `ARREADY_M0` = 1 in cycle N.
  - In N+1: `ARVALID_S` = 010, `ARID_S` = 0x13, `HandShake` = 1.
  - `outstanding` = 1 in N+2.
- Default slave with a stalled slave: M1 ARADDR = 0x1234_0000, ARREADY_S[2] held low for 5 cycles.
  - `ARVALID_S` = 100 and the payload stay stable for all 5 cycles; `ARREADY_M1` stays 0 throughout.
  - `HandShake` pulses on the cycle ARREADY_S[2] rises.
- Outstanding limit: issue 4 S0 reads with no RDONE.
  - A 5th request holds ARREADY = 0.
  - One RDONE pulse → `outstanding` = 3, and the 5th request is captured on the next cycle.
- Simultaneous events and saturation:
  - Slave accept and RDONE in the same cycle at count 2 → count stays 2.
  - RDONE at count 0 → count stays 0.
- Invalid grant and reset during SEND:
  - `grant_2M` = 11 with both ARVALIDs high → no ARREADY.
  - Assert ARESET while in SEND → all outputs return to their reset values on the next cycle.

Source files
------------

// File: rtl/ar_channel_router.sv
// AR channel router: captures the granted master's read request into a single
// holding register, decodes the target slave and drives it until accepted.
module ar_channel_router #(
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [15:0] S0_PAGE         = 16'h0000,
  parameter logic [15:0] S1_PAGE         = 16'h0001
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [1:0]  grant_2M,
  output logic        HandShake,
  input  logic [3:0]  ARID_M0,
  input  logic [3:0]  ARID_M1,
  input  logic [31:0] ARADDR_M0,
  input  logic [31:0] ARADDR_M1,
  input  logic [3:0]  ARLEN_M0,
  input  logic [3:0]  ARLEN_M1,
  input  logic [2:0]  ARSIZE_M0,
  input  logic [2:0]  ARSIZE_M1,
  input  logic [1:0]  ARBURST_M0,
  input  logic [1:0]  ARBURST_M1,
  input  logic        ARVALID_M0,
  input  logic        ARVALID_M1,
  output logic        ARREADY_M0,
  output logic        ARREADY_M1,
  output logic [7:0]  ARID_S,
  output logic [31:0] ARADDR_S,
  output logic [3:0]  ARLEN_S,
  output logic [2:0]  ARSIZE_S,
  output logic [1:0]  ARBURST_S,
  output logic [2:0]  ARVALID_S,
  input  logic [2:0]  ARREADY_S,
  input  logic        RDONE,
  output logic [2:0]  outstanding
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q;
  logic [2:0]  arvalid_q, outst_q, outst_d;
  logic [7:0]  id_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;

  logic        below_lim, take_m0, take_m1, take, accept;
  logic [7:0]  sel_id;
  logic [31:0] sel_addr;
  logic [3:0]  sel_len;
  logic [2:0]  sel_size, sel_tgt;
  logic [1:0]  sel_burst;

  assign below_lim  = outst_q < 3'(MAX_OUTSTANDING);
  assign take_m0    = (state_q == IDLE) && (grant_2M == 2'b01) && ARVALID_M0 && below_lim;
  assign take_m1    = (state_q == IDLE) && (grant_2M == 2'b10) && ARVALID_M1 && below_lim;
  assign take       = take_m0 | take_m1;
  // Only the currently targeted slave's ready bit can complete the transfer.
  assign accept     = (state_q == SEND) && |(arvalid_q & ARREADY_S);

  assign ARREADY_M0 = take_m0;
  assign ARREADY_M1 = take_m1;
  assign HandShake  = accept;

  assign sel_id    = take_m1 ? {4'b0010, ARID_M1} : {4'b0001, ARID_M0};
  assign sel_addr  = take_m1 ? ARADDR_M1  : ARADDR_M0;
  assign sel_len   = take_m1 ? ARLEN_M1   : ARLEN_M0;
  assign sel_size  = take_m1 ? ARSIZE_M1  : ARSIZE_M0;
  assign sel_burst = take_m1 ? ARBURST_M1 : ARBURST_M0;

  always_comb begin
    sel_tgt = 3'b100;
    if (sel_addr[31:16] == S0_PAGE)      sel_tgt = 3'b001;
    else if (sel_addr[31:16] == S1_PAGE) sel_tgt = 3'b010;
  end

  // Accept and completion in the same cycle cancel; completion at zero is dropped.
  always_comb begin
    outst_d = outst_q;
    case ({accept, RDONE})
      2'b10:   outst_d = outst_q + 3'd1;
      2'b01:   if (outst_q != 3'd0) outst_d = outst_q - 3'd1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      arvalid_q <= 3'b000;
      outst_q   <= 3'd0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
    end else begin
      outst_q <= outst_d;
      case (state_q)
        IDLE: if (take) begin
          state_q   <= SEND;
          arvalid_q <= sel_tgt;
          id_q      <= sel_id;
          addr_q    <= sel_addr;
          len_q     <= sel_len;
          size_q    <= sel_size;
          burst_q   <= sel_burst;
        end
        SEND: if (accept) begin
          state_q   <= IDLE;
          arvalid_q <= 3'b000;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ARVALID_S   = arvalid_q;
  assign ARID_S      = id_q;
  assign ARADDR_S    = addr_q;
  assign ARLEN_S     = len_q;
  assign ARSIZE_S    = size_q;
  assign ARBURST_S   = burst_q;
  assign outstanding = outst_q;

endmodule

// File: tb/tb_ar_channel_router.sv
// Directed bench for ar_channel_router with a scoreboard of master-side
// captures matched against slave-side accepts.
module tb_ar_channel_router;
  logic        ACLK = 1'b0, ARESET;
  logic [1:0]  grant_2M;
  logic        HandShake;
  logic [3:0]  ARID_M0, ARID_M1, ARLEN_M0, ARLEN_M1;
  logic [31:0] ARADDR_M0, ARADDR_M1;
  logic [2:0]  ARSIZE_M0, ARSIZE_M1;
  logic [1:0]  ARBURST_M0, ARBURST_M1;
  logic        ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic [2:0]  ARVALID_S, ARREADY_S;
  logic        RDONE;
  logic [2:0]  outstanding;

  int n_cmp = 0, n_err = 0;

  typedef struct packed {
    logic [7:0] id; logic [31:0] addr; logic [3:0] len;
    logic [2:0] size; logic [1:0] burst; logic [2:0] tgt;
  } ar_t;
  ar_t sb[$];

  ar_channel_router dut (
    .ACLK(ACLK), .ARESET(ARESET), .grant_2M(grant_2M), .HandShake(HandShake),
    .ARID_M0(ARID_M0), .ARID_M1(ARID_M1), .ARADDR_M0(ARADDR_M0), .ARADDR_M1(ARADDR_M1),
    .ARLEN_M0(ARLEN_M0), .ARLEN_M1(ARLEN_M1), .ARSIZE_M0(ARSIZE_M0), .ARSIZE_M1(ARSIZE_M1),
    .ARBURST_M0(ARBURST_M0), .ARBURST_M1(ARBURST_M1),
    .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1),
    .ARREADY_M0(ARREADY_M0), .ARREADY_M1(ARREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RDONE(RDONE), .outstanding(outstanding)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] decode(input logic [31:0] a);
    if (a[31:16] == 16'h0000) return 3'b001;
    if (a[31:16] == 16'h0001) return 3'b010;
    return 3'b100;
  endfunction

  // Scoreboard: push on master handshake, pop and compare on slave accept.
  always @(negedge ACLK) begin
    ar_t got, exp;
    if (!ARESET && ARREADY_M0)
      sb.push_back('{ {4'b0001, ARID_M0}, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0, decode(ARADDR_M0)});
    if (!ARESET && ARREADY_M1)
      sb.push_back('{ {4'b0010, ARID_M1}, ARADDR_M1, ARLEN_M1, ARSIZE_M1, ARBURST_M1, decode(ARADDR_M1)});
    if (|(ARVALID_S & ARREADY_S)) begin
      got = '{ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S};
      chk("sb_handshake", 64'(HandShake), 64'd1);
      if (sb.size() == 0) chk("sb_unexpected", 64'(got), 64'd0);
      else begin
        exp = sb.pop_front();
        chk("sb_payload", 64'(got), 64'(exp));
      end
    end
    if (ARESET) sb.delete();
  end

  task automatic nxt();
    @(posedge ACLK); #1;
  endtask

  task automatic neg();
    @(negedge ACLK);
  endtask

  // One M0 read to S0 with all slaves ready: 2 cycles, capture then accept.
  task automatic issue_m0(input logic [31:0] addr, input logic [3:0] id, input logic rd);
    grant_2M = 2'b01; ARVALID_M0 = 1'b1; ARADDR_M0 = addr; ARID_M0 = id;
    neg(); chk("issue_ready_m0", 64'(ARREADY_M0), 64'd1);
    nxt(); ARVALID_M0 = 1'b0; grant_2M = 2'b00; RDONE = rd;
    neg(); chk("issue_handshake", 64'(HandShake), 64'd1);
    nxt(); RDONE = 1'b0;
  endtask

  task automatic pulse_rdone(input int n);
    for (int i = 0; i < n; i++) begin RDONE = 1'b1; nxt(); end
    RDONE = 1'b0;
  endtask

  initial begin
    ARESET = 1'b1; grant_2M = 2'b00; RDONE = 1'b0; ARREADY_S = 3'b000;
    ARID_M0 = 4'h0; ARID_M1 = 4'h0; ARADDR_M0 = '0; ARADDR_M1 = '0;
    ARLEN_M0 = 4'd2; ARLEN_M1 = 4'd7; ARSIZE_M0 = 3'd2; ARSIZE_M1 = 3'd3;
    ARBURST_M0 = 2'd1; ARBURST_M1 = 2'd2; ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    neg();
    chk("rst_arvalid_s", 64'(ARVALID_S), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_arid_s", 64'(ARID_S), 64'd0);
    chk("rst_araddr_s", 64'(ARADDR_S), 64'd0);

    // Basic M0 path to S1
    nxt(); ARREADY_S = 3'b111;
    grant_2M = 2'b01; ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0001_0040; ARID_M0 = 4'd3;
    neg(); chk("m0_ready", 64'(ARREADY_M0), 64'd1);
    chk("m0_ready_m1", 64'(ARREADY_M1), 64'd0);
    nxt(); ARVALID_M0 = 1'b0; grant_2M = 2'b00;
    neg(); chk("m0_arvalid_s", 64'(ARVALID_S), 64'b010);
    chk("m0_arid_s", 64'(ARID_S), 64'h13);
    chk("m0_handshake", 64'(HandShake), 64'd1);
    nxt(); neg(); chk("m0_outstanding", 64'(outstanding), 64'd1);
    chk("m0_idle_arvalid", 64'(ARVALID_S), 64'd0);

    // Default slave with stall; non-target ready bits high must be ignored
    nxt(); ARREADY_S = 3'b011;
    grant_2M = 2'b10; ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h1234_0000; ARID_M1 = 4'd5;
    neg(); chk("m1_ready", 64'(ARREADY_M1), 64'd1);
    nxt(); ARADDR_M1 = 32'hDEAD_BEEF; grant_2M = 2'b01; ARVALID_M0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("stall_arvalid_s", 64'(ARVALID_S), 64'b100);
      chk("stall_araddr_s", 64'(ARADDR_S), 64'h1234_0000);
      chk("stall_arid_s", 64'(ARID_S), 64'h25);
      chk("stall_ready_m", 64'({ARREADY_M1, ARREADY_M0}), 64'd0);
      chk("stall_handshake", 64'(HandShake), 64'd0);
      nxt();
    end
    ARREADY_S = 3'b111; ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0; grant_2M = 2'b00;
    neg(); chk("stall_release_hs", 64'(HandShake), 64'd1);
    nxt(); neg(); chk("stall_outstanding", 64'(outstanding), 64'd2);

    // Drain to zero, then RDONE at zero saturates
    nxt(); pulse_rdone(2);
    neg(); chk("drain_zero", 64'(outstanding), 64'd0);
    nxt(); pulse_rdone(1);
    neg(); chk("sat_zero", 64'(outstanding), 64'd0);

    // Outstanding limit
    nxt();
    for (int i = 0; i < 4; i++) issue_m0(32'h0000_0100 + 32'(i * 4), 4'(i), 1'b0);
    neg(); chk("lim_count4", 64'(outstanding), 64'd4);
    nxt(); grant_2M = 2'b01; ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0000_0200; ARID_M0 = 4'd9;
    for (int i = 0; i < 3; i++) begin
      neg(); chk("lim_blocked", 64'(ARREADY_M0), 64'd0);
      nxt();
    end
    RDONE = 1'b1;
    neg(); chk("lim_blocked_rdone", 64'(ARREADY_M0), 64'd0);
    nxt(); RDONE = 1'b0;
    neg(); chk("lim_count3", 64'(outstanding), 64'd3);
    chk("lim_capture", 64'(ARREADY_M0), 64'd1);
    nxt(); ARVALID_M0 = 1'b0; grant_2M = 2'b00;
    neg(); chk("lim_hs", 64'(HandShake), 64'd1);
    nxt(); neg(); chk("lim_back4", 64'(outstanding), 64'd4);

    // Accept and RDONE together at count 2
    nxt(); pulse_rdone(2);
    neg(); chk("sim_pre2", 64'(outstanding), 64'd2);
    nxt(); issue_m0(32'h0000_0400, 4'hA, 1'b1);
    neg(); chk("sim_keep2", 64'(outstanding), 64'd2);

    // Invalid grants
    nxt(); grant_2M = 2'b11; ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1;
    neg(); chk("grant11_ready", 64'({ARREADY_M1, ARREADY_M0}), 64'd0);
    nxt(); grant_2M = 2'b00;
    neg(); chk("grant00_ready", 64'({ARREADY_M1, ARREADY_M0}), 64'd0);

    // Reset while in SEND drops the held request and clears the count
    nxt(); ARVALID_M1 = 1'b0; ARREADY_S = 3'b000;
    grant_2M = 2'b01; ARADDR_M0 = 32'h0000_0300; ARID_M0 = 4'hF;
    neg(); chk("rsend_ready", 64'(ARREADY_M0), 64'd1);
    nxt(); ARVALID_M0 = 1'b0; grant_2M = 2'b00; ARESET = 1'b1;
    neg(); chk("rsend_in_send", 64'(ARVALID_S), 64'b001);
    nxt(); ARESET = 1'b0;
    neg(); chk("rsend_arvalid", 64'(ARVALID_S), 64'd0);
    chk("rsend_outstanding", 64'(outstanding), 64'd0);
    chk("rsend_payload", 64'({ARID_S, ARLEN_S, ARSIZE_S, ARBURST_S}), 64'd0);
    chk("rsend_araddr", 64'(ARADDR_S), 64'd0);
    chk("rsend_hs", 64'(HandShake), 64'd0);

    nxt(); ARREADY_S = 3'b111;
    repeat (3) nxt();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
